// File: rtl/multicycle_control_fsm_pkg.sv
// Shared types for the multicycle RV32I sequencer: state encoding, opcodes,
// datapath select encodings and the per-state Moore control word.
package multicycle_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECR   = 4'd6,
        S_EXECI   = 4'd7,
        S_ALUWB   = 4'd8,
        S_BEQ     = 4'd9,
        S_JAL     = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD  = 2'b00,
        ALUOP_SUB  = 2'b01,
        ALUOP_FUNC = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'b00,
        RES_RDATA  = 2'b01,
        RES_ALURES = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_t;

    // fetch: IRWrite/PCUpdate armed, but only fire once memory reports ready
    typedef struct packed {
        logic        mem_req;
        logic        adr_src;
        logic        mem_write;
        logic        fetch;
        logic        pc_update;
        logic        reg_write;
        logic        branch;
        result_src_t result_src;
        src_a_t      src_a;
        src_b_t      src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_req    = 1'b1;
                c.fetch      = 1'b1;
                c.src_b      = SRCB_FOUR;
                c.result_src = RES_ALURES;
            end
            S_DECODE: begin
                c.src_a = SRCA_OLDPC;
                c.src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                c.src_a = SRCA_RS1;
                c.src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                c.mem_req = 1'b1;
                c.adr_src = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = RES_RDATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.mem_req   = 1'b1;
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECR: begin
                c.src_a  = SRCA_RS1;
                c.src_b  = SRCB_RS2;
                c.alu_op = ALUOP_FUNC;
            end
            S_EXECI: begin
                c.src_a  = SRCA_RS1;
                c.src_b  = SRCB_IMM;
                c.alu_op = ALUOP_FUNC;
            end
            S_ALUWB: begin
                c.result_src = RES_ALUOUT;
                c.reg_write  = 1'b1;
            end
            S_BEQ: begin
                c.src_a  = SRCA_RS1;
                c.src_b  = SRCB_RS2;
                c.alu_op = ALUOP_SUB;
                c.branch = 1'b1;
            end
            S_JAL: begin
                c.src_a     = SRCA_OLDPC;
                c.src_b     = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic imm_src_t imm_src_for(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from ALUOp and instruction function fields.
module alu_decoder (
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] ALUOp,
    output logic [2:0] ALUControl
);
    always_comb begin
        ALUControl = 3'b000;
        case (ALUOp)
            2'b00: ALUControl = 3'b000;
            2'b01: ALUControl = 3'b001;
            default: begin
                case (funct3)
                    // sub only for R-type with funct7[5]; addi never subtracts
                    3'b000:  ALUControl = (opb5 & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer stepping one RV32I instruction through fetch/decode/execute/
// memory/writeback, stalling on the unified memory's ready handshake.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
);
    state_t r_state;
    state_t w_next;
    ctrl_t  r_ctrl;
    ctrl_t  w_ctrl;
    logic   r_illegal;
    logic   w_fetch_done;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: w_next = S_MEMADR;
                    OP_RTYPE:          w_next = S_EXECR;
                    OP_ITYPE:          w_next = S_EXECI;
                    OP_BRANCH:         w_next = S_BEQ;
                    OP_JAL:            w_next = S_JAL;
                    default:           w_next = S_TRAP;
                endcase
            end
            S_MEMADR:  w_next = op[5] ? S_MEMWR : S_MEMREAD;
            S_MEMREAD: w_next = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWR:   w_next = mem_ready ? S_FETCH : S_MEMWR;
            S_MEMWB:   w_next = S_FETCH;
            S_EXECR:   w_next = S_ALUWB;
            S_EXECI:   w_next = S_ALUWB;
            S_JAL:     w_next = S_ALUWB;
            S_ALUWB:   w_next = S_FETCH;
            S_BEQ:     w_next = S_FETCH;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_FETCH;
        endcase
    end

    // Control word is registered from the next state so outputs stay Moore
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_ctrl    <= state_ctrl(S_FETCH);
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_ctrl    <= state_ctrl(w_next);
            r_illegal <= r_illegal | (w_next == S_TRAP);
        end
    end

    // Holding reset must kill strobes at once, even mid-MEMWR
    assign w_ctrl       = rst_n ? r_ctrl : state_ctrl(S_FETCH);
    assign w_fetch_done = w_ctrl.fetch & mem_ready;

    assign mem_req   = rst_n & w_ctrl.mem_req;
    assign AdrSrc    = w_ctrl.adr_src;
    assign MemWrite  = rst_n & w_ctrl.mem_write;
    assign IRWrite   = rst_n & w_fetch_done;
    assign PCWrite   = rst_n & (w_fetch_done | w_ctrl.pc_update | (w_ctrl.branch & zero));
    assign RegWrite  = rst_n & w_ctrl.reg_write;
    assign ResultSrc = w_ctrl.result_src;
    assign ALUSrcA   = w_ctrl.src_a;
    assign ALUSrcB   = w_ctrl.src_b;
    assign ImmSrc    = imm_src_for(op);
    assign illegal   = r_illegal;

    alu_decoder u_alu_decoder (
        .opb5       (op[5]),
        .funct3     (func3),
        .funct7b5   (func7),
        .ALUOp      (w_ctrl.alu_op),
        .ALUControl (ALUControl)
    );

endmodule
